// File: rtl/mem_responder.sv
// Byte-wide memory responder: block RAM in the low address space, and an I/O
// window in the top 8 bytes (TX byte FIFO, RX single-byte mailbox).
module mem_responder #(
  parameter int addr_width = 9,
  parameter int fifo_log2  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] mem_raddr,
  output logic [7:0]            mem_data_out,
  input  logic [addr_width-1:0] mem_waddr,
  input  logic [7:0]            mem_data_in,
  input  logic                  mem_write,
  output logic                  mem_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);
  localparam int depth = 1 << fifo_log2;
  localparam logic [addr_width-1:0] io_base = addr_width'((1 << addr_width) - 8);
  localparam logic [fifo_log2:0] depth_c = (fifo_log2+1)'(depth);

  logic [7:0] ram  [0:(1<<addr_width)-1];
  logic [7:0] fifo [0:depth-1];

  logic [fifo_log2-1:0] rd_ptr, wr_ptr;
  logic [fifo_log2:0]   count;
  logic                 overflow, mbox_full;
  logic [7:0]           mbox_data, io_rdata;
  logic [3:0]           count4;
  logic                 rd_io, wr_io, we, io_we, push_req, push, pop, full, empty;

  assign rd_io    = mem_raddr >= io_base;
  assign wr_io    = mem_waddr >= io_base;
  // A write coincident with reset must not land, even if mem_ready is still high.
  assign we       = mem_write & mem_ready & ~reset;
  assign io_we    = we & wr_io;
  assign full     = count == depth_c;
  assign empty    = count == '0;
  assign push_req = io_we & (mem_waddr[2:0] == 3'd0);
  assign push     = push_req & ~full;
  assign pop      = ~empty & tx_ready;
  assign count4   = 4'(count);

  assign tx_valid = ~empty;
  assign tx_data  = fifo[rd_ptr];
  assign rx_ready = ~mbox_full & mem_ready;

  always_comb begin
    io_rdata = 8'h00;
    case (mem_raddr[2:0])
      3'd1:    io_rdata = {count4, 1'b0, overflow, full, empty};
      3'd2:    io_rdata = mbox_data;
      3'd3:    io_rdata = {7'b0, mbox_full};
      default: io_rdata = 8'h00;
    endcase
  end

  // RAM has no reset; kept in its own process so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we && !wr_io) ram[mem_waddr] <= mem_data_in;
  end

  // Registered read; nonblocking semantics give read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (reset)          mem_data_out <= 8'h00;
    else if (mem_ready) mem_data_out <= rd_io ? io_rdata : ram[mem_raddr];
    else                mem_data_out <= 8'h00;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      mbox_full <= 1'b0;
      mbox_data <= 8'h00;
    end else begin
      mem_ready <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Full is judged on the registered count, so a same-cycle pop does not save the push.
      if (push_req && full)                          overflow <= 1'b1;
      else if (io_we && mem_waddr[2:0] == 3'd1)      overflow <= 1'b0;
      if (rx_valid && rx_ready) begin
        mbox_data <= rx_data;
        mbox_full <= 1'b1;
      end else if (io_we && mem_waddr[2:0] == 3'd3) begin
        mbox_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus queues expected read data and
// TX bytes; a negedge monitor pops and compares when the DUT presents them.
module tb_mem_responder;
  logic       clk, reset;
  logic [8:0] mem_raddr, mem_waddr;
  logic [7:0] mem_data_out, mem_data_in, tx_data, rx_data;
  logic       mem_write, mem_ready, tx_valid, tx_ready, rx_valid, rx_ready;

  mem_responder #(.addr_width(9), .fifo_log2(2)) dut (
    .clk(clk), .reset(reset),
    .mem_raddr(mem_raddr), .mem_data_out(mem_data_out),
    .mem_waddr(mem_waddr), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_ready(mem_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  logic       rd_chk = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
  endtask

  // Monitor: read data when the bench flags a read slot, TX bytes on each handshake.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rd_chk) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        $display("FAIL rd_unexpected: got 0x%02h with empty scoreboard", mem_data_out);
      end else begin
        e = rd_q.pop_front();
        chk("rd_data", mem_data_out, e);
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_chk++;
        $display("FAIL tx_unexpected: got 0x%02h with empty scoreboard", tx_data);
      end else begin
        e = tx_q.pop_front();
        chk("tx_data", tx_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    mem_waddr = a; mem_data_in = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic sample_rd(input logic [7:0] exp);
    rd_q.push_back(exp);
    rd_chk = 1'b1;
    @(negedge clk);
    #1 rd_chk = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [8:0] a, input logic [7:0] exp);
    mem_raddr = a;
    tick();
    sample_rd(exp);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (tx_valid && t < 20) begin tick(); t++; end
    chk({name, "_drained"}, {7'b0, tx_valid}, 8'h00);
  endtask

  initial begin
    reset = 1'b1; mem_raddr = '0; mem_waddr = '0; mem_data_in = '0; mem_write = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    tick(); tick();
    chk("rst_mem_ready", {7'b0, mem_ready}, 8'h00);
    chk("rst_tx_valid",  {7'b0, tx_valid},  8'h00);
    chk("rst_rx_ready",  {7'b0, rx_ready},  8'h00);
    chk("rst_data_out",  mem_data_out,      8'h00);
    reset = 1'b0;
    chk("first_cycle_ready", {7'b0, mem_ready}, 8'h00);
    tick();
    chk("ready_up", {7'b0, mem_ready}, 8'h01);
    chk("rx_ready_up", {7'b0, rx_ready}, 8'h01);

    // RAM write/read, IO write goes to FIFO not RAM
    wr(9'h010, 8'h5A);
    rd(9'h010, 8'h5A);
    wr(9'h1F8, 8'hFF);
    chk("io_push_valid", {7'b0, tx_valid}, 8'h01);
    rd(9'h1F9, 8'h10);
    rd(9'h1F8, 8'h00);
    rd(9'h1FC, 8'h00);
    tx_q.push_back(8'hFF);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("single_pop_empty", {7'b0, tx_valid}, 8'h00);

    // TX fill and overflow
    wr(9'h1F8, 8'h11); wr(9'h1F8, 8'h22); wr(9'h1F8, 8'h33); wr(9'h1F8, 8'h44);
    rd(9'h1F9, 8'h42);
    wr(9'h1F8, 8'h55);
    rd(9'h1F9, 8'h46);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    tx_ready = 1'b1;
    drain("fill");
    tx_ready = 1'b0;
    rd(9'h1F9, 8'h05);
    wr(9'h1F9, 8'h00);
    rd(9'h1F9, 8'h01);

    // Push and pop together at count 2, across pointer wrap
    wr(9'h1F8, 8'h60); wr(9'h1F8, 8'h61);
    tx_q.push_back(8'h60); tx_q.push_back(8'h61);
    mem_raddr = 9'h1F9;
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_waddr = 9'h1F8; mem_data_in = 8'h70 + 8'(i); mem_write = 1'b1;
      tx_q.push_back(8'h70 + 8'(i));
      tick();
      chk("pp_status", mem_data_out, 8'h20);
    end
    mem_write = 1'b0;
    drain("pp");
    tx_ready = 1'b0;
    rd(9'h1F9, 8'h01);

    // RX mailbox capture, hold-off and ack
    rx_valid = 1'b1; rx_data = 8'hA7;
    tick();
    rx_data = 8'hB8;
    chk("rx_full_ready", {7'b0, rx_ready}, 8'h00);
    rd(9'h1FB, 8'h01);
    rd(9'h1FA, 8'hA7);
    chk("rx_held_off", {7'b0, rx_ready}, 8'h00);
    wr(9'h1FB, 8'h00);
    chk("rx_after_ack", {7'b0, rx_ready}, 8'h01);
    tick();
    rx_valid = 1'b0;
    chk("rx_recapture", {7'b0, rx_ready}, 8'h00);
    rd(9'h1FA, 8'hB8);
    wr(9'h1FB, 8'h00);
    chk("rx_ack2", {7'b0, rx_ready}, 8'h01);

    // Read-before-write on a same-address collision
    wr(9'h020, 8'h01);
    mem_raddr = 9'h020;
    wr(9'h020, 8'h02);
    sample_rd(8'h01);
    rd(9'h020, 8'h02);

    // Reset mid-operation
    wr(9'h1F8, 8'hC1); wr(9'h1F8, 8'hC2); wr(9'h1F8, 8'hC3);
    rx_valid = 1'b1; rx_data = 8'h3C;
    tick();
    rx_valid = 1'b0;
    rd(9'h1F9, 8'h30);
    reset = 1'b1;
    mem_waddr = 9'h010; mem_data_in = 8'hEE; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    tick();
    chk("mid_rst_tx_valid",  {7'b0, tx_valid},  8'h00);
    chk("mid_rst_rx_ready",  {7'b0, rx_ready},  8'h00);
    chk("mid_rst_mem_ready", {7'b0, mem_ready}, 8'h00);
    reset = 1'b0;
    chk("post_rst_rx_ready", {7'b0, rx_ready}, 8'h00);
    tick();
    chk("post_rst_mem_ready", {7'b0, mem_ready}, 8'h01);
    chk("post_rst_rx_up",     {7'b0, rx_ready},  8'h01);
    rd(9'h1F9, 8'h01);
    rd(9'h1FB, 8'h00);
    rd(9'h1FA, 8'h00);
    rd(9'h010, 8'h5A);
    rd(9'h020, 8'h02);

    tick();
    chk("rd_q_left", 8'(rd_q.size()), 8'h00);
    chk("tx_q_left", 8'(tx_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
